// File: rtl/sa_queue_pkg.sv
// rtl/sa_queue_pkg.sv - shared widths and helpers for the system-agent queues
package sa_queue_pkg;

  localparam int DEF_WIDTH = 57;

  function automatic int IDX_W(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int CNT_W(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/prio_enc_lsb.sv
// rtl/prio_enc_lsb.sv - lowest-set-bit priority encoder with valid flag
module prio_enc_lsb
  import sa_queue_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]          req_i,
  output logic [IDX_W(N)-1:0]   idx_o,
  output logic                  vld_o
);

  localparam int IW = IDX_W(N);

  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IW'(i);
    end
  end

  assign vld_o = |req_i;

endmodule

// File: rtl/sa_tx_slot_queue.sv
// rtl/sa_tx_slot_queue.sv - slot-based TX queue with lowest-free allocation,
// mask/pop freeing and an age matrix tracking the oldest live entry
module sa_tx_slot_queue
  import sa_queue_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_dat,
  output logic                       wr_rdy,
  output logic [IDX_W(DEPTH)-1:0]    wr_idx,
  output logic                       wr_ovf,
  input  logic [DEPTH-1:0]           clr_mask,
  input  logic                       pop,
  output logic [DEPTH-1:0]           used,
  output logic [CNT_W(DEPTH)-1:0]    count,
  output logic                       empty,
  output logic                       oldest_vld,
  output logic [IDX_W(DEPTH)-1:0]    oldest_idx,
  output logic [WIDTH-1:0]           dat_out [DEPTH]
);

  localparam int CW = CNT_W(DEPTH);

  logic [DEPTH-1:0] used_q, used_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q;
  logic [DEPTH-1:0] age_q [DEPTH];
  logic [WIDTH-1:0] regs_q [DEPTH];

  logic             alloc_vld, oldest_any, acc;
  logic [DEPTH-1:0] is_oldest, alloc_oh, pop_oh, free_m;
  int               n_freed;

  prio_enc_lsb #(.N(DEPTH)) u_alloc_enc (
    .req_i (~used_q),
    .idx_o (wr_idx),
    .vld_o (alloc_vld)
  );

  // A live slot is oldest when no other live slot claims to be older than it.
  always_comb begin
    is_oldest = '0;
    for (int i = 0; i < DEPTH; i++) begin
      is_oldest[i] = used_q[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (used_q[j] && age_q[j][i]) is_oldest[i] = 1'b0;
      end
    end
  end

  prio_enc_lsb #(.N(DEPTH)) u_oldest_enc (
    .req_i (is_oldest),
    .idx_o (oldest_idx),
    .vld_o (oldest_any)
  );

  assign acc = wr_en & alloc_vld;

  always_comb begin
    alloc_oh = '0;
    pop_oh   = '0;
    if (acc) alloc_oh[wr_idx] = 1'b1;
    if (pop && oldest_any) pop_oh[oldest_idx] = 1'b1;
    free_m = clr_mask | pop_oh;
    used_d = (used_q & ~free_m) | alloc_oh;
    n_freed = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (free_m[i] && used_q[i]) n_freed = n_freed + 1;
    end
    cnt_d = CW'(int'(cnt_q) + int'(acc) - n_freed);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      used_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i]  <= '0;
        regs_q[i] <= '0;
      end
    end else begin
      used_q <= used_d;
      cnt_q  <= cnt_d;
      ovf_q  <= wr_en & ~alloc_vld;
      if (acc) begin
        regs_q[wr_idx] <= wr_dat;
        // New entry is younger than every slot that survives this cycle.
        for (int j = 0; j < DEPTH; j++) begin
          if (j == int'(wr_idx)) age_q[j] <= '0;
          else age_q[j][wr_idx] <= used_q[j] & ~free_m[j];
        end
      end
    end
  end

  assign wr_rdy     = alloc_vld;
  assign wr_ovf     = ovf_q;
  assign used       = used_q;
  assign count      = cnt_q;
  assign empty      = (cnt_q == '0);
  assign oldest_vld = ~empty;
  assign dat_out    = regs_q;

endmodule

// File: tb/tb_sa_tx_slot_queue.sv
// tb/tb_sa_tx_slot_queue.sv - directed self-checking bench, DEPTH=8/WIDTH=57 and DEPTH=5/WIDTH=16
module tb_sa_tx_slot_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        a_wr_en, a_wr_rdy, a_wr_ovf, a_pop, a_empty, a_oldest_vld;
  logic [56:0] a_wr_dat;
  logic [2:0]  a_wr_idx, a_oldest_idx;
  logic [7:0]  a_clr, a_used;
  logic [3:0]  a_count;
  logic [56:0] a_dat [8];

  logic        b_wr_en, b_wr_rdy, b_wr_ovf, b_pop, b_empty, b_oldest_vld;
  logic [15:0] b_wr_dat;
  logic [2:0]  b_wr_idx, b_oldest_idx;
  logic [4:0]  b_clr, b_used;
  logic [2:0]  b_count;
  logic [15:0] b_dat [5];

  int n_assert = 0;
  int n_fail   = 0;

  int a_pop_exp [8] = '{1, 2, 3, 4, 5, 6, 7, 0};
  int b_pop_exp [5] = '{0, 1, 3, 4, 2};

  sa_tx_slot_queue #(.WIDTH(57), .DEPTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(a_wr_en), .wr_dat(a_wr_dat), .wr_rdy(a_wr_rdy),
    .wr_idx(a_wr_idx), .wr_ovf(a_wr_ovf), .clr_mask(a_clr), .pop(a_pop), .used(a_used),
    .count(a_count), .empty(a_empty), .oldest_vld(a_oldest_vld), .oldest_idx(a_oldest_idx),
    .dat_out(a_dat)
  );

  sa_tx_slot_queue #(.WIDTH(16), .DEPTH(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(b_wr_en), .wr_dat(b_wr_dat), .wr_rdy(b_wr_rdy),
    .wr_idx(b_wr_idx), .wr_ovf(b_wr_ovf), .clr_mask(b_clr), .pop(b_pop), .used(b_used),
    .count(b_count), .empty(b_empty), .oldest_vld(b_oldest_vld), .oldest_idx(b_oldest_idx),
    .dat_out(b_dat)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("a_count_popcount", 64'(a_count), 64'($countones(a_used)));
      chk("b_count_popcount", 64'(b_count), 64'($countones(b_used)));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_wr_en = 0; a_wr_dat = '0; a_clr = '0; a_pop = 0;
    b_wr_en = 0; b_wr_dat = '0; b_clr = '0; b_pop = 0;
    repeat (2) step();
    chk("rst_used",       64'(a_used), 64'h0);
    chk("rst_count",      64'(a_count), 64'h0);
    chk("rst_wr_rdy",     64'(a_wr_rdy), 64'h1);
    chk("rst_wr_idx",     64'(a_wr_idx), 64'h0);
    chk("rst_empty",      64'(a_empty), 64'h1);
    chk("rst_oldest_vld", 64'(a_oldest_vld), 64'h0);
    chk("rst_oldest_idx", 64'(a_oldest_idx), 64'h0);
    chk("rst_wr_ovf",     64'(a_wr_ovf), 64'h0);
    chk("rst_dat0",       64'(a_dat[0]), 64'h0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      chk("fill_wr_idx", 64'(a_wr_idx), 64'(i));
      a_wr_en = 1; a_wr_dat = 57'(32'h100 + i);
      step();
    end
    a_wr_en = 0;
    for (int i = 0; i < 8; i++) chk("fill_dat", 64'(a_dat[i]), 64'(32'h100 + i));
    chk("full_count",  64'(a_count), 64'd8);
    chk("full_wr_rdy", 64'(a_wr_rdy), 64'h0);
    chk("full_used",   64'(a_used), 64'hFF);
    chk("full_oldest", 64'(a_oldest_idx), 64'h0);
    chk("full_empty",  64'(a_empty), 64'h0);

    a_wr_en = 1; a_wr_dat = 57'h1FF;
    step();
    a_wr_en = 0;
    chk("ovf_pulse", 64'(a_wr_ovf), 64'h1);
    chk("ovf_count", 64'(a_count), 64'd8);
    chk("ovf_dat0",  64'(a_dat[0]), 64'h100);
    chk("ovf_dat7",  64'(a_dat[7]), 64'h107);
    step();
    chk("ovf_one_cycle", 64'(a_wr_ovf), 64'h0);

    a_clr = 8'b0010_0100;
    step();
    a_clr = '0;
    chk("clr_used",   64'(a_used), 64'hDB);
    chk("clr_count",  64'(a_count), 64'd6);
    chk("clr_wr_idx", 64'(a_wr_idx), 64'd2);
    chk("clr_wr_rdy", 64'(a_wr_rdy), 64'h1);
    a_wr_en = 1; a_wr_dat = 57'hAA;
    step();
    a_wr_en = 0;
    chk("clr_wr_dat",  64'(a_dat[2]), 64'hAA);
    chk("clr_wr_cnt",  64'(a_count), 64'd7);
    chk("clr_oldest",  64'(a_oldest_idx), 64'd0);
    chk("clr_retain5", 64'(a_dat[5]), 64'h105);
    a_wr_en = 1; a_wr_dat = 57'hAB;
    step();
    chk("refill_count", 64'(a_count), 64'd8);
    a_pop = 1;
    step();
    a_wr_en = 0; a_pop = 0;
    chk("full_wr_pop_used",  64'(a_used), 64'hFE);
    chk("full_wr_pop_count", 64'(a_count), 64'd7);
    chk("full_wr_pop_ovf",   64'(a_wr_ovf), 64'h1);
    chk("full_wr_pop_old",   64'(a_oldest_idx), 64'd1);

    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_used",   64'(a_used), 64'h0);
    chk("async_rst_wr_rdy", 64'(a_wr_rdy), 64'h1);
    chk("async_rst_count",  64'(a_count), 64'h0);
    chk("async_rst_dat2",   64'(a_dat[2]), 64'h0);
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      a_wr_en = 1; a_wr_dat = 57'(32'h200 + i);
      step();
    end
    a_wr_en = 0; a_clr = 8'h01;
    step();
    a_clr = '0;
    chk("reuse_wr_idx", 64'(a_wr_idx), 64'd0);
    a_wr_en = 1; a_wr_dat = 57'h2FF;
    step();
    a_wr_en = 0;
    for (int i = 0; i < 8; i++) begin
      chk("pop_order", 64'(a_oldest_idx), 64'(a_pop_exp[i]));
      a_pop = 1;
      step();
      a_pop = 0;
    end
    chk("pop_empty",      64'(a_empty), 64'h1);
    chk("pop_oldest_vld", 64'(a_oldest_vld), 64'h0);
    chk("pop_count",      64'(a_count), 64'd0);
    a_pop = 1;
    step();
    a_pop = 0;
    chk("pop_when_empty", 64'(a_used), 64'h0);

    for (int i = 0; i < 3; i++) begin
      a_wr_en = 1; a_wr_dat = 57'(32'h300 + i);
      step();
    end
    chk("wp_pre_idx", 64'(a_wr_idx), 64'd3);
    a_wr_dat = 57'h333; a_pop = 1;
    step();
    a_wr_en = 0; a_pop = 0;
    chk("wp_used",   64'(a_used), 64'h0E);
    chk("wp_count",  64'(a_count), 64'd3);
    chk("wp_oldest", 64'(a_oldest_idx), 64'd1);
    chk("wp_dat3",   64'(a_dat[3]), 64'h333);
    a_clr = 8'h11;
    step();
    a_clr = '0;
    chk("clr_free_used",  64'(a_used), 64'h0E);
    chk("clr_free_count", 64'(a_count), 64'd3);

    for (int i = 0; i < 5; i++) begin
      chk("b_fill_idx", 64'(b_wr_idx), 64'(i));
      b_wr_en = 1; b_wr_dat = 16'(16'h10 + i);
      step();
    end
    b_wr_en = 0;
    chk("b_full_count", 64'(b_count), 64'd5);
    chk("b_full_rdy",   64'(b_wr_rdy), 64'h0);
    chk("b_full_used",  64'(b_used), 64'h1F);
    chk("b_dat4",       64'(b_dat[4]), 64'h14);
    b_wr_en = 1; b_wr_dat = 16'hFFFF;
    step();
    b_wr_en = 0;
    chk("b_ovf",       64'(b_wr_ovf), 64'h1);
    chk("b_ovf_dat0",  64'(b_dat[0]), 64'h10);
    b_clr = 5'b00100;
    step();
    b_clr = '0;
    chk("b_clr_used", 64'(b_used), 64'h1B);
    chk("b_clr_idx",  64'(b_wr_idx), 64'd2);
    b_wr_en = 1; b_wr_dat = 16'h55;
    step();
    b_wr_en = 0;
    chk("b_wr_dat2", 64'(b_dat[2]), 64'h55);
    for (int i = 0; i < 5; i++) begin
      chk("b_pop_order", 64'(b_oldest_idx), 64'(b_pop_exp[i]));
      b_pop = 1;
      step();
      b_pop = 0;
    end
    chk("b_empty", 64'(b_empty), 64'h1);
    chk("b_count", 64'(b_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
